// File: rtl/cnn_stream_feeder.sv
// Streams a full weight set then a full image from word memory into a CNN core.
// Reads are tagged at issue so each returned word leaves on the matching strobe.
module cnn_stream_feeder #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 306,
  parameter int IMAGE_HEIGHT    = 306,
  parameter int CHANNEL_NUM_IN  = 64,
  parameter int CHANNEL_NUM_OUT = 64,
  parameter int KERNEL          = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] IMAGE_BASE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  valid_weight_in,
  output logic [DATA_WIDTH-1:0] weight_in,
  output logic                  valid_in,
  output logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  busy,
  output logic                  done
);

  localparam int WEIGHT_NUM  = CHANNEL_NUM_IN * CHANNEL_NUM_OUT * KERNEL * KERNEL;
  localparam int PIXEL_NUM   = CHANNEL_NUM_IN * IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int MAX_NUM     = (WEIGHT_NUM > PIXEL_NUM) ? WEIGHT_NUM : PIXEL_NUM;
  localparam int CNT_W       = $clog2(MAX_NUM + 1);
  localparam int RD_LATENCY  = 1;

  localparam logic [CNT_W-1:0] WEIGHT_LAST = CNT_W'(WEIGHT_NUM - 1);
  localparam logic [CNT_W-1:0] PIXEL_LAST  = CNT_W'(PIXEL_NUM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WEIGHT = 2'd1,
    PIXEL  = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [ADDR_WIDTH-1:0]  last_addr_reg;
  logic                   issue;
  logic                   issue_pixel;
  logic [ADDR_WIDTH-1:0]  issue_addr;
  logic                   flush_done;

  // One tag stage per cycle of memory latency; the last stage lines up with mem_rd_data.
  logic [RD_LATENCY-1:0]  tag_valid_reg;
  logic [RD_LATENCY-1:0]  tag_pixel_reg;

  logic                   valid_weight_reg;
  logic [DATA_WIDTH-1:0]  weight_reg;
  logic                   valid_pxl_reg;
  logic [DATA_WIDTH-1:0]  pxl_reg;

  // The last pixel is out once nothing remains in the tag pipe.
  assign flush_done = (state_reg == FLUSH) && valid_pxl_reg && !(|tag_valid_reg);

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    issue       = 1'b0;
    issue_pixel = 1'b0;
    issue_addr  = last_addr_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WEIGHT;
          count_next = '0;
        end
      end
      WEIGHT: begin
        if (!stall) begin
          issue      = 1'b1;
          issue_addr = WEIGHT_BASE + ADDR_WIDTH'(count_reg);
          if (count_reg == WEIGHT_LAST) begin
            state_next = PIXEL;
            count_next = '0;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
      end
      PIXEL: begin
        if (!stall) begin
          issue       = 1'b1;
          issue_pixel = 1'b1;
          issue_addr  = IMAGE_BASE + ADDR_WIDTH'(count_reg);
          if (count_reg == PIXEL_LAST) begin
            state_next = FLUSH;
            count_next = '0;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      last_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (issue) begin
        last_addr_reg <= issue_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid_reg[0] <= 1'b0;
      tag_pixel_reg[0] <= 1'b0;
    end else begin
      tag_valid_reg[0] <= issue;
      tag_pixel_reg[0] <= issue_pixel;
    end
  end

  generate
    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_tag_stage
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_pixel_reg[gi] <= 1'b0;
        end else begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
          tag_pixel_reg[gi] <= tag_pixel_reg[gi-1];
        end
      end
    end
  endgenerate

  // Data registers only load on their own strobe so they hold between words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_weight_reg <= 1'b0;
      weight_reg       <= '0;
      valid_pxl_reg    <= 1'b0;
      pxl_reg          <= '0;
    end else begin
      valid_weight_reg <= tag_valid_reg[RD_LATENCY-1] && !tag_pixel_reg[RD_LATENCY-1];
      valid_pxl_reg    <= tag_valid_reg[RD_LATENCY-1] &&  tag_pixel_reg[RD_LATENCY-1];
      if (tag_valid_reg[RD_LATENCY-1] && !tag_pixel_reg[RD_LATENCY-1]) begin
        weight_reg <= mem_rd_data;
      end
      if (tag_valid_reg[RD_LATENCY-1] && tag_pixel_reg[RD_LATENCY-1]) begin
        pxl_reg <= mem_rd_data;
      end
    end
  end

  assign mem_rd_en       = issue;
  assign mem_addr        = issue_addr;
  assign valid_weight_in = valid_weight_reg;
  assign weight_in       = weight_reg;
  assign valid_in        = valid_pxl_reg;
  assign pxl_in          = pxl_reg;
  assign busy            = (state_reg != IDLE);
  assign done            = flush_done;

endmodule

// File: doc/cnn_stream_feeder.md
CNN_STREAM_FEEDER -- requirements
Module: cnn_stream_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning pixel/weight word width.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 306, meaning pixels per row.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 306, meaning rows per channel.
REQ-004 SHALL have parameter CHANNEL_NUM_IN, default 64, meaning input channels.
REQ-005 SHALL have parameter CHANNEL_NUM_OUT, default 64, meaning output channels.
REQ-006 SHALL have parameter KERNEL, default 3, meaning kernel width.
REQ-007 SHALL have parameter ADDR_WIDTH, default 32, meaning memory word-address width.
REQ-008 SHALL have parameters WEIGHT_BASE, default 0, and IMAGE_BASE, default 0, meaning word base addresses of each region.
REQ-009 SHALL derive WEIGHT_NUM = CHANNEL_NUM_IN*CHANNEL_NUM_OUT*KERNEL*KERNEL and PIXEL_NUM = CHANNEL_NUM_IN*IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-010 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low reset.
REQ-011 SHALL have ports: start  in  1  launch pulse; stall  in  1  suspend read issue.
REQ-012 SHALL have ports: mem_rd_en  out  1  read strobe; mem_addr  out  ADDR_WIDTH  read word address; mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after its strobe.
REQ-013 SHALL have ports: valid_weight_in  out  1  weight strobe; weight_in  out  DATA_WIDTH  weight word; valid_in  out  1  pixel strobe; pxl_in  out  DATA_WIDTH  pixel word (channel-major, row-major in channel).
REQ-014 SHALL have ports: busy  out  1  sequence in progress; done  out  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, WEIGHT, PIXEL, FLUSH.
REQ-016 IDLE: start=1 at an edge -> WEIGHT, read counter cleared, busy=1 from that edge; start in any other state SHALL be ignored.
REQ-017 WEIGHT: each cycle with stall=0, mem_rd_en=1, mem_addr=WEIGHT_BASE+count, count+1; after issuing count WEIGHT_NUM-1 -> PIXEL, count cleared.
REQ-018 PIXEL: same rule with IMAGE_BASE and PIXEL_NUM; after issuing last pixel address -> FLUSH.
REQ-019 stall=1 in WEIGHT/PIXEL: mem_rd_en=0, count and state held; mem_addr holds last value.
REQ-020 Each issued read SHALL carry a registered tag (weight/pixel); in the cycle after the data cycle the matching strobe (valid_weight_in or valid_in) SHALL be 1 with data = mem_rd_data, i.e. 2-cycle latency strobe-to-output; the other strobe SHALL be 0.
REQ-021 An in-flight read SHALL complete and be emitted even if stall rises after its issue.
REQ-022 With stall=0 throughout, outputs SHALL be gap-free: WEIGHT_NUM consecutive weight strobes immediately followed by PIXEL_NUM consecutive pixel strobes.
REQ-023 valid_weight_in and valid_in SHALL never be 1 in the same cycle; data outputs SHALL hold last value when strobe is 0.
REQ-024 FLUSH: remain until the last pixel is emitted; in that same cycle done=1; next edge -> IDLE with busy=0.
REQ-025 Counters SHALL be sized for max(WEIGHT_NUM, PIXEL_NUM) without overflow; address arithmetic wraps modulo 2^ADDR_WIDTH.
REQ-026 start in the cycle done=1 SHALL be ignored; a new sequence requires start while in IDLE.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, clear counters and tag pipeline, and drive mem_rd_en, mem_addr, valid_weight_in, weight_in, valid_in, pxl_in, busy, done to 0.
REQ-028 Reset mid-sequence SHALL abandon in-flight reads with no strobe emitted after release; first activity after release requires a new start.

Verification (IMAGE_WIDTH=4, IMAGE_HEIGHT=4, CHANNEL_NUM_IN=2, CHANNEL_NUM_OUT=2, KERNEL=3, WEIGHT_BASE=0x100, IMAGE_BASE=0x200; memory model returns data = address)
REQ-029 Start pulse, stall=0 -> addresses 0x100..0x123 then 0x200..0x21F consecutive; 36 weight strobes (0x100..0x123) then 32 pixel strobes (0x200..0x21F) gap-free; first weight strobe 2 cycles after first mem_rd_en; done single pulse with last pixel 0x21F; busy then 0.
REQ-030 stall=1 for 3 cycles while issuing address 0x110 -> 0x10F still emitted, no strobe for 3 cycles, stream resumes 0x110 with no loss or duplicate.
REQ-031 stall asserted across weight/pixel boundary (after 0x123 issue) -> 0x123 emitted, then 0x200 follows on release; never both strobes high.
REQ-032 start re-pulsed while busy and in done cycle -> ignored; exactly 68 strobes, one done.
REQ-033 reset=0 asynchronously during pixel 0x208 issue -> all outputs 0 immediately, no strobe after release; new start repeats full REQ-029 sequence.
